// File: rtl/sscan_snap_buf_if.sv
// Capture/dump port bundle for the shadow-scan snapshot buffer.
// master drives snapshots and dump requests, slave is the buffer itself.
interface sscan_snap_buf_if #(
    parameter int DATA_W = 94,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              snap;
    logic [DATA_W-1:0] snap_data;
    logic              mode_wrap;
    logic              dump_en;
    logic              ch_out;
    logic              ch_out_vld;
    logic              ch_out_done;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              overflow;

    modport master (
        output snap, snap_data, mode_wrap, dump_en,
        input  ch_out, ch_out_vld, ch_out_done, count, full, overflow
    );

    modport slave (
        input  snap, snap_data, mode_wrap, dump_en,
        output ch_out, ch_out_vld, ch_out_done, count, full, overflow
    );
endinterface

// File: rtl/sscan_snap_buf.sv
// Shadow-scan snapshot buffer: captures up to DEPTH debug vectors into a
// circular buffer and dumps them oldest-first, LSB-first, on a 1-bit chain.
module sscan_snap_buf #(
    parameter int DATA_W = 94,
    parameter int DEPTH  = 4
) (
    input logic             sh_clk,
    input logic             sh_rst,
    sscan_snap_buf_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx, rd_ptr, rd_ptr_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_nx;
    logic              snap_f;
    logic              ovf, ovf_nx;
    logic              late_ovf, late_ovf_nx;
    logic              wr_en;
    logic              ch_out_q, ch_vld_q, ch_done_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        state_nx    = state;
        wr_ptr_nx   = wr_ptr;
        rd_ptr_nx   = rd_ptr;
        cnt_nx      = cnt;
        bit_cnt_nx  = bit_cnt;
        ovf_nx      = ovf;
        late_ovf_nx = late_ovf;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (snap_f) begin
                    if (cnt != CNT_W'(DEPTH)) begin
                        wr_en     = 1'b1;
                        wr_ptr_nx = ptr_inc(wr_ptr);
                        cnt_nx    = cnt + CNT_W'(1);
                    end else if (bus.mode_wrap) begin
                        wr_en     = 1'b1;
                        wr_ptr_nx = ptr_inc(wr_ptr);
                        rd_ptr_nx = ptr_inc(rd_ptr);
                        ovf_nx    = 1'b1;
                    end else begin
                        ovf_nx = 1'b1;
                    end
                end
                // count after this cycle's capture decides dump vs empty dump
                if (bus.dump_en) begin
                    bit_cnt_nx = '0;
                    state_nx   = (cnt_nx != '0) ? DUMP : DONE;
                end
            end
            DUMP: begin
                // drops during a dump belong to the next dump's overflow window
                if (snap_f) begin
                    ovf_nx      = 1'b1;
                    late_ovf_nx = 1'b1;
                end
                if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                    bit_cnt_nx = '0;
                    rd_ptr_nx  = ptr_inc(rd_ptr);
                    cnt_nx     = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nx = DONE;
                end else begin
                    bit_cnt_nx = bit_cnt + BIT_W'(1);
                end
            end
            DONE: begin
                ovf_nx      = late_ovf;
                late_ovf_nx = 1'b0;
                state_nx    = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cnt       <= '0;
            bit_cnt   <= '0;
            snap_f    <= 1'b0;
            ovf       <= 1'b0;
            late_ovf  <= 1'b0;
            ch_out_q  <= 1'b0;
            ch_vld_q  <= 1'b0;
            ch_done_q <= 1'b0;
        end else begin
            state     <= state_nx;
            wr_ptr    <= wr_ptr_nx;
            rd_ptr    <= rd_ptr_nx;
            cnt       <= cnt_nx;
            bit_cnt   <= bit_cnt_nx;
            snap_f    <= bus.snap;
            ovf       <= ovf_nx;
            late_ovf  <= late_ovf_nx;
            ch_out_q  <= (state == DUMP) & mem[rd_ptr][bit_cnt];
            ch_vld_q  <= (state == DUMP);
            ch_done_q <= (state == DONE);
        end
    end

    always_ff @(posedge sh_clk) begin
        if (wr_en) mem[wr_ptr] <= bus.snap_data;
    end

    assign bus.ch_out      = ch_out_q;
    assign bus.ch_out_vld  = ch_vld_q;
    assign bus.ch_out_done = ch_done_q;
    assign bus.count       = cnt;
    assign bus.full        = (cnt == CNT_W'(DEPTH));
    assign bus.overflow    = ovf;
endmodule

// File: tb/tb_sscan_snap_buf.sv
// Bench for sscan_snap_buf: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_sscan_snap_buf;
    localparam int DW = 8;
    localparam int DP = 4;

    logic sh_clk = 1'b0;
    logic sh_rst;
    always #5 sh_clk = ~sh_clk;

    sscan_snap_buf_if #(.DATA_W(DW), .DEPTH(DP)) bus ();
    sscan_snap_buf #(.DATA_W(DW), .DEPTH(DP)) dut (.sh_clk(sh_clk), .sh_rst(sh_rst), .bus(bus));

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: stored snapshots as a queue, dump as a phase + bit index.
    logic [DW-1:0] m_q[$];
    int  m_bit, m_phase;   // phase 0 idle, 1 dumping, 2 done
    bit  m_ovf, m_late, m_snapd;
    bit  e_out, e_vld, e_done;

    always @(posedge sh_clk or posedge sh_rst) begin
        if (sh_rst) begin
            m_q.delete();
            m_bit = 0; m_phase = 0; m_ovf = 0; m_late = 0; m_snapd = 0;
            e_out = 0; e_vld = 0; e_done = 0;
        end else begin
            bit cap;
            cap = m_snapd;
            m_snapd = bus.snap;
            e_vld  = (m_phase == 1);
            e_out  = e_vld ? m_q[0][m_bit] : 1'b0;
            e_done = (m_phase == 2);
            case (m_phase)
                0: begin
                    if (cap) begin
                        if (m_q.size() < DP) m_q.push_back(bus.snap_data);
                        else if (bus.mode_wrap) begin
                            void'(m_q.pop_front());
                            m_q.push_back(bus.snap_data);
                            m_ovf = 1;
                        end else m_ovf = 1;
                    end
                    if (bus.dump_en) begin
                        m_bit = 0;
                        m_phase = (m_q.size() > 0) ? 1 : 2;
                    end
                end
                1: begin
                    if (cap) begin m_ovf = 1; m_late = 1; end
                    m_bit++;
                    if (m_bit == DW) begin
                        void'(m_q.pop_front());
                        m_bit = 0;
                        if (m_q.size() == 0) m_phase = 2;
                    end
                end
                default: begin
                    m_ovf = m_late; m_late = 0; m_phase = 0;
                end
            endcase
        end
    end

    int cyc = 0;
    always @(posedge sh_clk) cyc++;

    // Compare process plus collection of dumped bytes for literal checks
    logic [DW-1:0] got[$];
    logic [DW-1:0] acc;
    int acc_n = 0, vld_cnt = 0, done_cnt = 0, done_cyc = 0;

    always @(negedge sh_clk) begin
        if (sh_rst) acc_n = 0;
        else begin
            check("ch_out_vld", 32'(bus.ch_out_vld), 32'(e_vld));
            check("ch_out", 32'(bus.ch_out), 32'(e_out));
            check("ch_out_done", 32'(bus.ch_out_done), 32'(e_done));
            check("count", 32'(bus.count), 32'(m_q.size()));
            check("full", 32'(bus.full), 32'(m_q.size() == DP));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (bus.ch_out_vld) begin
                vld_cnt++;
                acc = {bus.ch_out, acc[DW-1:1]};
                acc_n++;
                if (acc_n == DW) begin got.push_back(acc); acc_n = 0; end
            end
            if (bus.ch_out_done) begin done_cnt++; done_cyc = cyc; end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sh_clk);
        #1;
    endtask

    task automatic snap_one(input logic [DW-1:0] d);
        bus.snap = 1'b1; tick(1);
        bus.snap = 1'b0; bus.snap_data = d; tick(2);
    endtask

    task automatic snap_six;
        for (int i = 0; i <= 6; i++) begin
            bus.snap = (i < 6);
            bus.snap_data = 8'(i);
            tick(1);
        end
        tick(1);
    endtask

    task automatic start_dump(output int v0, output int d0);
        got.delete();
        v0 = vld_cnt; d0 = done_cnt;
        bus.dump_en = 1'b1; tick(1);
        bus.dump_en = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 300) begin tick(1); k++; end
        check("done_pulse_seen", 32'(done_cnt - d0), 32'd1);
        tick(1);
    endtask

    task automatic full_dump(output int nvld);
        int v0, d0;
        start_dump(v0, d0);
        wait_done(d0);
        nvld = vld_cnt - v0;
    endtask

    initial begin
        int nv, v0, d0, c0, k;
        sh_rst = 1'b1;
        bus.snap = 1'b0; bus.snap_data = '0; bus.mode_wrap = 1'b0; bus.dump_en = 1'b0;
        tick(3);
        sh_rst = 1'b0;
        tick(1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_vld", 32'(bus.ch_out_vld), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_full", 32'(bus.full), 32'd0);

        // single snapshot, 0xA5 -> 1,0,1,0,0,1,0,1
        snap_one(8'hA5);
        check("s1_count", 32'(bus.count), 32'd1);
        full_dump(nv);
        check("s1_vld_len", 32'(nv), 32'd8);
        check("s1_nbytes", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("s1_byte", 32'(got[0]), 32'hA5);
        check("s1_count_after", 32'(bus.count), 32'd0);
        check("s1_ovf_after", 32'(bus.overflow), 32'd0);

        // six snaps, stop-when-full
        snap_six();
        check("s2_count", 32'(bus.count), 32'd4);
        check("s2_full", 32'(bus.full), 32'd1);
        check("s2_ovf", 32'(bus.overflow), 32'd1);
        full_dump(nv);
        check("s2_vld_len", 32'(nv), 32'd32);
        check("s2_nbytes", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("s2_byte", 32'(got[i]), 32'(i + 1));
        check("s2_ovf_after", 32'(bus.overflow), 32'd0);

        // six snaps, overwrite-oldest
        bus.mode_wrap = 1'b1;
        snap_six();
        check("s3_ovf", 32'(bus.overflow), 32'd1);
        full_dump(nv);
        check("s3_nbytes", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++) check("s3_byte", 32'(got[i]), 32'(i + 3));
        check("s3_ovf_after", 32'(bus.overflow), 32'd0);
        bus.mode_wrap = 1'b0;

        // empty dump: done two cycles after dump_en, no valid bits
        c0 = cyc;
        start_dump(v0, d0);
        wait_done(d0);
        check("s4_done_lat", 32'(done_cyc - c0), 32'd2);
        check("s4_vld_len", 32'(vld_cnt - v0), 32'd0);

        // snap during dump is dropped, overflow survives the done
        snap_one(8'h11);
        snap_one(8'h22);
        start_dump(v0, d0);
        tick(3);
        bus.snap = 1'b1; tick(1);
        bus.snap = 1'b0; bus.snap_data = 8'h77; tick(1);
        wait_done(d0);
        check("s5_nbytes", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            check("s5_byte0", 32'(got[0]), 32'h11);
            check("s5_byte1", 32'(got[1]), 32'h22);
        end
        check("s5_ovf_after", 32'(bus.overflow), 32'd1);
        check("s5_count", 32'(bus.count), 32'd0);
        snap_one(8'h33);
        full_dump(nv);
        check("s5b_nbytes", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("s5b_byte", 32'(got[0]), 32'h33);
        check("s5b_ovf_after", 32'(bus.overflow), 32'd0);

        // reset at bit 3 of a three-entry dump
        snap_one(8'hC1);
        snap_one(8'hC2);
        snap_one(8'hC3);
        start_dump(v0, d0);
        k = 0;
        while (vld_cnt - v0 < 3 && k < 50) begin tick(1); k++; end
        check("s6_bits_before_rst", 32'(vld_cnt - v0), 32'd3);
        check("s6_count_pre", 32'(bus.count), 32'd3);
        sh_rst = 1'b1;
        #1;
        check("s6_rst_vld", 32'(bus.ch_out_vld), 32'd0);
        check("s6_rst_out", 32'(bus.ch_out), 32'd0);
        check("s6_rst_done", 32'(bus.ch_out_done), 32'd0);
        check("s6_rst_count", 32'(bus.count), 32'd0);
        check("s6_rst_ovf", 32'(bus.overflow), 32'd0);
        tick(2);
        sh_rst = 1'b0;
        tick(4);
        check("s6_no_done", 32'(done_cnt - d0), 32'd0);
        snap_one(8'h5A);
        full_dump(nv);
        check("s6b_nbytes", 32'(got.size()), 32'd1);
        if (got.size() == 1) check("s6b_byte", 32'(got[0]), 32'h5A);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
